// File: rtl/ahb_counter_pkg.sv
// Shared types, register offsets and helpers for the AHB-lite counter front end.
package ahb_counter_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    // Halfword-aligned register byte offsets
    localparam logic [3:0] CTRL_ADDR     = 4'h0;
    localparam logic [3:0] ROLLOVER_ADDR = 4'h2;
    localparam logic [3:0] COUNT_ADDR    = 4'h4;
    localparam logic [3:0] STATUS_ADDR   = 4'h6;
    localparam logic [3:0] IRQ_EN_ADDR   = 4'h8;
    // Highest legal byte address (upper byte of IRQ_EN)
    localparam logic [3:0] LAST_ADDR     = 4'h9;

    // One-hot register select bit positions (index = haddr[3:1])
    localparam int NUM_REGS     = 5;
    localparam int SEL_CTRL     = 0;
    localparam int SEL_ROLLOVER = 1;
    localparam int SEL_COUNT    = 2;
    localparam int SEL_STATUS   = 3;
    localparam int SEL_IRQ_EN   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } err_state_t;

    // Bit mask of the byte lanes touched by an access
    function automatic logic [15:0] lane_mask(input logic byte_acc, input logic lane_hi);
        if (!byte_acc) begin
            return 16'hFFFF;
        end else if (lane_hi) begin
            return 16'hFF00;
        end else begin
            return 16'h00FF;
        end
    endfunction

endpackage

// File: rtl/ahb_lite_addr_decode.sv
// Address-phase capture and legality check for the counter register block.
module ahb_lite_addr_decode
    import ahb_counter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                accept_i,
    input  logic [3:0]          haddr_i,
    input  logic [2:0]          hsize_i,
    input  logic                hwrite_i,
    output logic                addr_err_o,
    output logic                dp_valid_o,
    output logic                dp_write_o,
    output logic [NUM_REGS-1:0] dp_sel_o,
    output logic [15:0]         dp_lane_mask_o
);

    logic [NUM_REGS-1:0] sel_d;
    logic                illegal;

    logic                dp_valid_q;
    logic                dp_write_q;
    logic [NUM_REGS-1:0] dp_sel_q;
    logic [15:0]         dp_lane_mask_q;

    // Register index is the halfword number; out-of-range indices select nothing
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_sel
            assign sel_d[gi] = (haddr_i[3:1] == 3'(gi));
        end
    endgenerate

    // Flag accesses that must be answered with a two-cycle ERROR response
    always_comb begin
        illegal = 1'b0;
        if (haddr_i > LAST_ADDR)                             illegal = 1'b1;
        if (hsize_i > 3'd1)                                  illegal = 1'b1;
        if ((hsize_i == 3'd1) && haddr_i[0])                 illegal = 1'b1;
        if (hwrite_i && (haddr_i[3:1] == COUNT_ADDR[3:1]))   illegal = 1'b1;
    end

    assign addr_err_o = accept_i & illegal;

    // Latch the accepted address phase; an erroring one never reaches a data phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_valid_q     <= 1'b0;
            dp_write_q     <= 1'b0;
            dp_sel_q       <= '0;
            dp_lane_mask_q <= '0;
        end else begin
            dp_valid_q <= accept_i & ~illegal;
            if (accept_i) begin
                dp_write_q     <= hwrite_i;
                dp_sel_q       <= sel_d;
                dp_lane_mask_q <= lane_mask(hsize_i == 3'd0, haddr_i[0]);
            end
        end
    end

    assign dp_valid_o     = dp_valid_q;
    assign dp_write_o     = dp_write_q;
    assign dp_sel_o       = dp_sel_q;
    assign dp_lane_mask_o = dp_lane_mask_q;

endmodule

// File: rtl/ahb_counter_ctrl.sv
// AHB-lite register front end driving an external flex_counter.
module ahb_counter_ctrl
    import ahb_counter_pkg::*;
#(
    parameter int                  NUM_BITS     = 4,
    parameter logic [NUM_BITS-1:0] ROLLOVER_RST = '1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hsel,
    input  logic [3:0]          haddr,
    input  logic [1:0]          htrans,
    input  logic [2:0]          hsize,
    input  logic                hwrite,
    input  logic [15:0]         hwdata,
    output logic [15:0]         hrdata,
    output logic                hready,
    output logic                hresp,
    input  logic [NUM_BITS-1:0] count_out,
    input  logic                rollover_flag,
    output logic                count_enable,
    output logic                clear,
    output logic [NUM_BITS-1:0] rollover_val,
    output logic                irq
);

    htrans_t             trans_type;
    logic                accept;
    logic                addr_err;
    logic                dp_valid;
    logic                dp_write;
    logic [NUM_REGS-1:0] dp_sel;
    logic [15:0]         dp_lane_mask;
    logic [NUM_REGS-1:0] wr_sel;

    logic                ctrl_en_q,   ctrl_en_d;
    logic                clear_q,     clear_d;
    logic [NUM_BITS-1:0] rollover_q,  rollover_d;
    logic                roll_q,      roll_d;
    logic                irq_en_q,    irq_en_d;
    logic                flag_prev_q;

    err_state_t          state_q;
    logic                hready_q;
    logic                hresp_q;

    logic [15:0]         count_word;
    logic [15:0]         rd_word;
    logic                unused_hwdata;

    assign trans_type = htrans_t'(htrans);
    assign accept     = hsel && hready_q &&
                        ((trans_type == HTRANS_NONSEQ) || (trans_type == HTRANS_SEQ));

    ahb_lite_addr_decode u_decode (
        .clk            (clk),
        .rst            (rst),
        .accept_i       (accept),
        .haddr_i        (haddr),
        .hsize_i        (hsize),
        .hwrite_i       (hwrite),
        .addr_err_o     (addr_err),
        .dp_valid_o     (dp_valid),
        .dp_write_o     (dp_write),
        .dp_sel_o       (dp_sel),
        .dp_lane_mask_o (dp_lane_mask)
    );

    // Per-register write strobes, active during a write data phase
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_wr
            assign wr_sel[gi] = dp_valid & dp_write & dp_sel[gi];
        end
    endgenerate

    // Next-state of the bus-visible registers; writes use hwdata of the data phase
    always_comb begin
        ctrl_en_d  = ctrl_en_q;
        clear_d    = 1'b0;
        rollover_d = rollover_q;
        roll_d     = roll_q;
        irq_en_d   = irq_en_q;

        if (wr_sel[SEL_CTRL] && dp_lane_mask[0]) begin
            ctrl_en_d = hwdata[0];
        end
        if (wr_sel[SEL_CTRL] && dp_lane_mask[1] && hwdata[1]) begin
            clear_d = 1'b1;
        end
        if (wr_sel[SEL_ROLLOVER]) begin
            rollover_d = (rollover_q & ~dp_lane_mask[NUM_BITS-1:0]) |
                         (hwdata[NUM_BITS-1:0] & dp_lane_mask[NUM_BITS-1:0]);
        end
        if (wr_sel[SEL_IRQ_EN] && dp_lane_mask[0]) begin
            irq_en_d = hwdata[0];
        end
        // A new rollover edge takes priority over a simultaneous W1C
        if (rollover_flag && !flag_prev_q) begin
            roll_d = 1'b1;
        end else if (wr_sel[SEL_STATUS] && dp_lane_mask[0] && hwdata[0]) begin
            roll_d = 1'b0;
        end
    end

    // Register state and the edge detector on the counter's rollover flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en_q   <= 1'b0;
            clear_q     <= 1'b0;
            rollover_q  <= ROLLOVER_RST;
            roll_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            flag_prev_q <= 1'b0;
        end else begin
            ctrl_en_q   <= ctrl_en_d;
            clear_q     <= clear_d;
            rollover_q  <= rollover_d;
            roll_q      <= roll_d;
            irq_en_q    <= irq_en_d;
            flag_prev_q <= rollover_flag;
        end
    end

    // Read mux; COUNT is taken live from the counter during the data phase
    always_comb begin
        count_word                 = '0;
        count_word[NUM_BITS-1:0]   = count_out;
        rd_word                    = '0;
        if (dp_sel[SEL_CTRL])     rd_word[0]            = ctrl_en_q;
        if (dp_sel[SEL_ROLLOVER]) rd_word[NUM_BITS-1:0] = rollover_q;
        if (dp_sel[SEL_COUNT])    rd_word               = count_word;
        if (dp_sel[SEL_STATUS])   rd_word[0]            = roll_q;
        if (dp_sel[SEL_IRQ_EN])   rd_word[0]            = irq_en_q;
        hrdata = '0;
        if (dp_valid && !dp_write) begin
            hrdata = rd_word & dp_lane_mask;
        end
    end

    // Two-cycle ERROR response sequencer with registered hready/hresp
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (addr_err) begin
                        state_q  <= ERR1;
                        hready_q <= 1'b0;
                        hresp_q  <= 1'b1;
                    end
                end
                ERR1: begin
                    state_q  <= ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= 1'b1;
                end
                ERR2: begin
                    if (addr_err) begin
                        state_q  <= ERR1;
                        hready_q <= 1'b0;
                        hresp_q  <= 1'b1;
                    end else begin
                        state_q  <= IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= 1'b0;
                end
            endcase
        end
    end

    // Only some write-data bits map onto implemented register bits
    assign unused_hwdata = ^hwdata;

    assign hready       = hready_q;
    assign hresp        = hresp_q;
    assign count_enable = ctrl_en_q;
    assign clear        = clear_q;
    assign rollover_val = rollover_q;
    assign irq          = roll_q & irq_en_q;

endmodule

// File: tb/tb_ahb_counter_ctrl.sv
// Directed + random bench for ahb_counter_ctrl with a behavioural register model
// and a simple flex_counter stand-in driving count_out / rollover_flag.
module tb_ahb_counter_ctrl;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          hsel;
    logic [3:0]    haddr;
    logic [1:0]    htrans;
    logic [2:0]    hsize;
    logic          hwrite;
    logic [15:0]   hwdata;
    logic [15:0]   hrdata;
    logic          hready;
    logic          hresp;
    logic [NB-1:0] cnt;
    logic          cnt_flag;
    logic          count_enable;
    logic          clear;
    logic [NB-1:0] rollover_val;
    logic          irq;

    // Reference model state
    logic          m_ctrl_en;
    logic [NB-1:0] m_rollover;
    logic          m_irq_en;
    logic          m_roll;
    logic          m_flag_last;
    logic          w1c_req;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ahb_counter_ctrl #(.NUM_BITS(NB)) dut (
        .clk           (clk),
        .rst           (rst),
        .hsel          (hsel),
        .haddr         (haddr),
        .htrans        (htrans),
        .hsize         (hsize),
        .hwrite        (hwrite),
        .hwdata        (hwdata),
        .hrdata        (hrdata),
        .hready        (hready),
        .hresp         (hresp),
        .count_out     (cnt),
        .rollover_flag (cnt_flag),
        .count_enable  (count_enable),
        .clear         (clear),
        .rollover_val  (rollover_val),
        .irq           (irq)
    );

    // flex_counter stand-in: counts 1..rollover_val, flag while at rollover_val
    assign cnt_flag = (cnt == rollover_val);
    always @(posedge clk or posedge rst) begin
        if (rst)               cnt <= '0;
        else if (clear)        cnt <= '0;
        else if (count_enable) cnt <= (cnt == rollover_val) ? NB'(1) : cnt + 1'b1;
    end

    // Sticky ROLL expectation: set on each new flag assertion, W1C otherwise
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_roll      <= 1'b0;
            m_flag_last <= 1'b0;
        end else begin
            if (cnt_flag && !m_flag_last) m_roll <= 1'b1;
            else if (w1c_req)             m_roll <= 1'b0;
            m_flag_last <= cnt_flag;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_err(input logic [3:0] a, input logic [2:0] sz, input logic wr);
        return (a > 4'd9) || (sz > 3'd1) || ((sz == 3'd1) && a[0]) ||
               (wr && ((a == 4'h4) || (a == 4'h5)));
    endfunction

    function automatic logic [15:0] lanes(input logic [2:0] sz, input logic [3:0] a);
        if (sz != 3'd0) return 16'hFFFF;
        return a[0] ? 16'hFF00 : 16'h00FF;
    endfunction

    function automatic logic [15:0] model_word(input logic [3:0] a);
        case (a[3:1])
            3'd0:    return {15'd0, m_ctrl_en};
            3'd1:    return 16'(m_rollover);
            3'd2:    return 16'(cnt);
            3'd3:    return {15'd0, m_roll};
            3'd4:    return {15'd0, m_irq_en};
            default: return 16'd0;
        endcase
    endfunction

    task automatic model_write(input logic [3:0] a, input logic [15:0] lm, input logic [15:0] dm);
        case (a[3:1])
            3'd0: if (lm[0]) m_ctrl_en = dm[0];
            3'd1: m_rollover = (m_rollover & ~lm[NB-1:0]) | dm[NB-1:0];
            3'd4: if (lm[0]) m_irq_en = dm[0];
            default: ;
        endcase
    endtask

    task automatic reset_model();
        m_ctrl_en  = 1'b0;
        m_rollover = '1;
        m_irq_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; haddr = '0; hsize = '0;
        hwdata = '0; w1c_req = 1'b0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic side_checks(input string tag);
        chk({tag, "_irq"}, 16'(irq), 16'(m_roll & m_irq_en));
        chk({tag, "_cnt_en"}, 16'(count_enable), 16'(m_ctrl_en));
        chk({tag, "_rollover_val"}, 16'(rollover_val), 16'(m_rollover));
    endtask

    // One non-pipelined transfer; returns read data (0 for writes/errors)
    task automatic access(input logic [3:0] a, input logic [2:0] sz, input logic wr,
                          input logic [15:0] d, output logic [15:0] rd);
        logic [15:0] lm, dm;
        bit          err;
        err = is_err(a, sz, wr);
        lm  = lanes(sz, a);
        dm  = d & lm;
        rd  = '0;
        $display("txn addr=%h size=%0d write=%0d data=%h expect_err=%0d", a, sz, wr, d, err);
        hsel = 1'b1; haddr = a; hsize = sz; hwrite = wr; htrans = 2'd2;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0;
        if (err) begin
            chk($sformatf("err1_hready@%h", a), 16'(hready), 16'd0);
            chk($sformatf("err1_hresp@%h", a), 16'(hresp), 16'd1);
            @(posedge clk); #1;
            chk($sformatf("err2_hready@%h", a), 16'(hready), 16'd1);
            chk($sformatf("err2_hresp@%h", a), 16'(hresp), 16'd1);
            @(posedge clk); #1;
            chk($sformatf("post_err_hresp@%h", a), 16'(hresp), 16'd0);
        end else begin
            chk($sformatf("ok_hready@%h", a), 16'(hready), 16'd1);
            chk($sformatf("ok_hresp@%h", a), 16'(hresp), 16'd0);
            if (wr) begin
                hwdata  = d;
                w1c_req = (a[3:1] == 3'd3) && dm[0];
                @(posedge clk); #1;
                hwdata  = '0;
                w1c_req = 1'b0;
                model_write(a, lm, dm);
                chk($sformatf("clear@%h", a), 16'(clear), 16'((a[3:1] == 3'd0) && dm[1]));
            end else begin
                rd = hrdata;
                chk($sformatf("rdata@%h/sz%0d", a, sz), hrdata, model_word(a) & lm);
                @(posedge clk); #1;
            end
        end
        side_checks("post");
    endtask

    task automatic check_reset_values(input string tag);
        logic [3:0]  addrs [4];
        logic [15:0] exps  [4];
        logic [15:0] rd;
        addrs = '{4'h0, 4'h2, 4'h6, 4'h8};
        exps  = '{16'h0000, 16'h000F, 16'h0000, 16'h0000};
        chk({tag, "_hready"}, 16'(hready), 16'd1);
        chk({tag, "_hresp"}, 16'(hresp), 16'd0);
        chk({tag, "_irq"}, 16'(irq), 16'd0);
        chk({tag, "_clear"}, 16'(clear), 16'd0);
        for (int i = 0; i < 4; i++) begin
            access(addrs[i], 3'd1, 1'b0, 16'd0, rd);
            chk($sformatf("%s_reg@%h", tag, addrs[i]), rd, exps[i]);
        end
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] exp_seq [6];
        logic [3:0]  ra;
        logic [2:0]  rs;
        logic        rw;
        exp_seq = '{16'd1, 16'd2, 16'd3, 16'd1, 16'd2, 16'd3};

        // 1. reset values
        do_reset();
        check_reset_values("rst");

        // 2. counting, ROLL, irq, W1C
        access(4'h2, 3'd1, 1'b1, 16'h0003, rd);
        access(4'h0, 3'd1, 1'b1, 16'h0001, rd);
        hsel = 1'b1; haddr = 4'h4; hsize = 3'd1; hwrite = 1'b0; htrans = 2'd2;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("count_seq%0d", i), hrdata, exp_seq[i]);
        end
        hsel = 1'b0; htrans = 2'd0;
        @(posedge clk); #1;
        access(4'h6, 3'd1, 1'b0, 16'd0, rd);
        chk("status_roll_set", rd, 16'h0001);
        access(4'h0, 3'd1, 1'b1, 16'h0000, rd);
        access(4'h8, 3'd1, 1'b1, 16'h0001, rd);
        chk("irq_on", 16'(irq), 16'd1);
        access(4'h6, 3'd1, 1'b1, 16'h0001, rd);
        chk("irq_off", 16'(irq), 16'd0);
        access(4'h6, 3'd1, 1'b0, 16'd0, rd);
        chk("status_cleared", rd, 16'h0000);

        // 3. CLR pulse
        access(4'h0, 3'd1, 1'b1, 16'h0003, rd);
        chk("clr_pulse_hi", 16'(clear), 16'd1);
        chk("clr_cnt_en", 16'(count_enable), 16'd1);
        @(posedge clk); #1;
        chk("clr_pulse_lo", 16'(clear), 16'd0);
        access(4'h0, 3'd1, 1'b0, 16'd0, rd);
        chk("ctrl_readback", rd, 16'h0001);

        // 4. errors; address phases during ERR1 ignored; back-to-back error from ERR2
        access(4'h4, 3'd1, 1'b1, 16'h00FF, rd);
        access(4'hA, 3'd1, 1'b0, 16'd0, rd);
        hsel = 1'b1; haddr = 4'hA; hsize = 3'd1; hwrite = 1'b0; htrans = 2'd2;
        @(posedge clk); #1;
        chk("errA_e1_hready", 16'(hready), 16'd0);
        haddr = 4'h8; hwrite = 1'b1;
        @(posedge clk); #1;
        hwdata = 16'h0000;
        chk("errA_e2_hresp", 16'(hresp), 16'd1);
        haddr = 4'hB; hwrite = 1'b0;
        @(posedge clk); #1;
        chk("errB_e1_hready", 16'(hready), 16'd0);
        chk("errB_e1_hresp", 16'(hresp), 16'd1);
        hsel = 1'b0; htrans = 2'd0;
        @(posedge clk); #1;
        chk("errB_e2_hready", 16'(hready), 16'd1);
        @(posedge clk); #1;
        chk("errB_idle_hresp", 16'(hresp), 16'd0);
        access(4'h8, 3'd1, 1'b0, 16'd0, rd);
        chk("irq_en_unchanged", rd, 16'h0001);

        // 5. byte lanes
        access(4'h2, 3'd1, 1'b1, 16'h000F, rd);
        access(4'h3, 3'd0, 1'b1, 16'hAB00, rd);
        chk("byte_hi_masked", 16'(rollover_val), 16'h000F);
        access(4'h2, 3'd0, 1'b0, 16'd0, rd);
        chk("byte_lo_read", rd, 16'h000F);
        access(4'h2, 3'd0, 1'b1, 16'h000A, rd);
        access(4'h3, 3'd0, 1'b0, 16'd0, rd);
        chk("byte_hi_read", rd, 16'h0000);

        // read-after-write, pipelined
        hsel = 1'b1; haddr = 4'h2; hsize = 3'd1; hwrite = 1'b1; htrans = 2'd2;
        @(posedge clk); #1;
        hwdata = 16'h0007; hwrite = 1'b0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'd0; hwdata = '0;
        m_rollover = 4'h7;
        chk("raw_rollover", hrdata, 16'h0007);
        @(posedge clk); #1;

        // 6. reset mid-transfer
        access(4'h0, 3'd1, 1'b1, 16'h0003, rd);
        rst = 1'b1; #1;
        chk("rst_clear_drop", 16'(clear), 16'd0);
        do_reset();
        hsel = 1'b1; haddr = 4'h2; hsize = 3'd1; hwrite = 1'b1; htrans = 2'd2;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; hwdata = 16'h0005;
        #2; rst = 1'b1; #1;
        do_reset();
        hsel = 1'b1; haddr = 4'hC; hsize = 3'd1; hwrite = 1'b0; htrans = 2'd2;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'd0;
        chk("pre_rst_err_hready", 16'(hready), 16'd0);
        rst = 1'b1; #1;
        chk("rst_fsm_hready", 16'(hready), 16'd1);
        chk("rst_fsm_hresp", 16'(hresp), 16'd0);
        do_reset();
        check_reset_values("midrst");

        // random traffic against the model
        for (int i = 0; i < 80; i++) begin
            ra = 4'($urandom_range(0, 11));
            rs = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            access(ra, rs, rw, 16'($urandom), rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
